// File: rtl/mem_req_arbiter.sv
// Arbitrates the IF and EX/MEM requesters onto one SRAM-like port and routes in-order
// responses back to the owner recorded at address-phase accept time.
module mem_req_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_inst_req,
  input  logic        i_inst_wr,
  input  logic [1:0]  i_inst_size,
  input  logic [31:0] i_inst_addr,
  input  logic [3:0]  i_inst_wstrb,
  input  logic [31:0] i_inst_wdata,
  output logic        o_inst_addr_ok,
  output logic        o_inst_data_ok,
  output logic [31:0] o_inst_rdata,
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [31:0] i_data_addr,
  input  logic [3:0]  i_data_wstrb,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_addr_ok,
  output logic        o_data_data_ok,
  output logic [31:0] o_data_rdata,
  output logic        o_req,
  output logic        o_wr,
  output logic [1:0]  o_size,
  output logic [31:0] o_addr,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic        i_addr_ok,
  input  logic        i_data_ok,
  input  logic [31:0] i_rdata,
  output logic        o_resp_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STREAK_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD_I = 2'd1;
  localparam logic [1:0] S_HOLD_D = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [DEPTH-1:0] r_owner;  // 1 = data side
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_streak;
  logic [SW-1:0]    w_streak_nxt;
  logic             r_resp_err;

  logic w_sel_d;
  logic w_sel_i;
  logic w_sel_req;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_owner;

  always_comb begin
    w_sel_d = 1'b0;
    w_sel_i = 1'b0;
    unique case (r_state)
      S_HOLD_I: w_sel_i = 1'b1;
      S_HOLD_D: w_sel_d = 1'b1;
      default: begin
        // A full streak of data grants yields one slot to a waiting fetch.
        w_sel_d = i_data_req & ~(i_inst_req & (r_streak == STREAK_LIM));
        w_sel_i = ~w_sel_d & i_inst_req;
      end
    endcase
  end

  assign w_sel_req = (w_sel_d & i_data_req) | (w_sel_i & i_inst_req);
  assign w_full    = (r_count == FULL_CNT);
  assign o_req     = w_sel_req & ~w_full;
  assign w_push    = o_req & i_addr_ok;

  assign o_wr    = w_sel_i ? i_inst_wr    : i_data_wr;
  assign o_size  = w_sel_i ? i_inst_size  : i_data_size;
  assign o_addr  = w_sel_i ? i_inst_addr  : i_data_addr;
  assign o_wstrb = w_sel_i ? i_inst_wstrb : i_data_wstrb;
  assign o_wdata = w_sel_i ? i_inst_wdata : i_data_wdata;

  assign o_inst_addr_ok = w_push & w_sel_i;
  assign o_data_addr_ok = w_push & w_sel_d;

  assign w_owner        = r_owner[r_rd_ptr];
  assign w_pop          = i_data_ok & (r_count != '0);
  assign o_data_data_ok = w_pop & w_owner;
  assign o_inst_data_ok = w_pop & ~w_owner;
  assign o_inst_rdata   = i_rdata;
  assign o_data_rdata   = i_rdata;
  assign o_resp_err     = r_resp_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_HOLD_I: if (w_push || !i_inst_req) w_state_nxt = S_IDLE;
      S_HOLD_D: if (w_push || !i_data_req) w_state_nxt = S_IDLE;
      default:  if (o_req && !i_addr_ok) w_state_nxt = w_sel_d ? S_HOLD_D : S_HOLD_I;
    endcase
  end

  always_comb begin
    w_streak_nxt = r_streak;
    if (w_push && w_sel_d && i_inst_req) begin
      if (r_streak != STREAK_LIM) w_streak_nxt = r_streak + SW'(1);
    end else if ((w_push && w_sel_i) || !i_inst_req) begin
      w_streak_nxt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_streak   <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_owner[r_wr_ptr] <= w_sel_d;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_data_ok && r_count == '0) r_resp_err <= 1'b1;
    end
  end

endmodule
